// File: rtl/down_counter_timer_pkg.sv
// down_counter_timer_pkg: shared state encoding and default width for the down counter timer
package down_counter_timer_pkg;
  localparam int DEFAULT_WIDTH = 4;
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
endpackage

// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable down counter / interval timer with one-shot, periodic and pause modes
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_periodic,
  output logic [WIDTH-1:0] o_count,
  output logic             o_busy,
  output logic             o_tc
);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_count, r_reload, w_count_nxt, w_reload_nxt;
  logic             r_tc, w_tc_nxt;
  // next state, count, reload and terminal pulse; load overrides any start/stop, stop beats start
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_reload_nxt = r_reload;
    w_tc_nxt     = 1'b0;
    if (i_load) begin
      w_reload_nxt = i_load_val;
      w_count_nxt  = i_load_val;
      w_state_nxt  = IDLE;
    end else begin
      case (r_state)
        IDLE: w_state_nxt = (i_start && r_count != '0) ? RUN : IDLE;
        RUN: begin
          if (i_stop) begin
            w_state_nxt = HOLD;
          end else if (r_count == ONE) begin
            w_tc_nxt    = 1'b1;
            w_count_nxt = i_periodic ? r_reload : '0;
            w_state_nxt = i_periodic ? RUN : IDLE;
          end else if (r_count == '0) begin
            w_state_nxt = IDLE;
          end else begin
            w_count_nxt = r_count - ONE;
          end
        end
        HOLD: w_state_nxt = (i_start && !i_stop) ? RUN : HOLD;
        default: w_state_nxt = IDLE;
      endcase
    end
  end
  // state, count and reload registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_reload <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_reload <= w_reload_nxt;
    end
  end
  // registered terminal-count pulse, aligned with the post-terminal count value
  always_ff @(posedge i_clk) begin
    if (!i_rst) r_tc <= 1'b0;
    else        r_tc <= w_tc_nxt;
  end
  assign o_count = r_count;
  assign o_busy  = (r_state == RUN) || (r_state == HOLD);
  assign o_tc    = r_tc;
endmodule
